// File: rtl/asc_controller_pkg.sv
// Shared types and register map for the line-drawer Avalon controller.
package asc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        DRAW   = 2'd2
    } asc_state_t;

    localparam logic [2:0] ADDR_MODE   = 3'b000;
    localparam logic [2:0] ADDR_STATUS = 3'b001;
    localparam logic [2:0] ADDR_GO     = 3'b010;
    localparam logic [2:0] ADDR_START  = 3'b011;
    localparam logic [2:0] ADDR_END    = 3'b100;
    localparam logic [2:0] ADDR_COLOUR = 3'b101;

endpackage

// File: rtl/asc_controller_if.sv
// Avalon-MM slave bus between the host and the line-drawer controller.
interface asc_controller_if;

    logic       avs_read;
    logic       avs_write;
    logic [2:0] avs_address;
    logic       avs_waitrequest;

    modport master (
        output avs_read,
        output avs_write,
        output avs_address,
        input  avs_waitrequest
    );

    modport slave (
        input  avs_read,
        input  avs_write,
        input  avs_address,
        output avs_waitrequest
    );

endinterface

// File: rtl/asc_controller_timeout_counter.sv
// Draw watchdog: counts DRAW cycles and flags when the abort limit is reached.
module asc_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/asc_controller.sv
// Avalon-MM controller that launches the line drawer and stalls or polls the host.
// Optional draw watchdog enabled by defining ASC_CTRL_TIMEOUT_EN.
module asc_controller
    import asc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    asc_controller_if.slave  avs,
    input  logic             mode,
    output logic             set_mode,
    output logic             set_start,
    output logic             set_end,
    output logic             set_colour,
    output logic             start,
    output logic             done,
    output logic             line_go,
    input  logic             line_done,
    output logic             line_abort,
    output logic             timeout_flag
);

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("asc_controller: TIMEOUT_CYCLES must be at least 2");
    end

    asc_state_t state;
    logic       start_q;
    logic       idle_write;
    logic       go_accept;
    logic       timeout_hit;
    logic       draw_end;

    // Only IDLE accepts writes; busy-state writes are either stalled or dropped.
    assign idle_write = (state == IDLE) && avs.avs_write;
    assign go_accept  = idle_write && (avs.avs_address == ADDR_GO);
    assign draw_end   = (state == DRAW) && (line_done || timeout_hit);

    assign avs.avs_waitrequest = !mode && (state != IDLE) && (avs.avs_read || avs.avs_write);

    always_comb begin
        set_mode   = 1'b0;
        set_start  = 1'b0;
        set_end    = 1'b0;
        set_colour = 1'b0;
        if (idle_write) begin
            case (avs.avs_address)
                ADDR_MODE:   set_mode   = 1'b1;
                ADDR_START:  set_start  = 1'b1;
                ADDR_END:    set_end    = 1'b1;
                ADDR_COLOUR: set_colour = 1'b1;
                default:     ;
            endcase
        end
    end

    assign done    = draw_end;
    assign start   = start_q;
    assign line_go = start_q;

`ifdef ASC_CTRL_TIMEOUT_EN
    logic tmo_expired;
    logic cnt_clear;
    logic cnt_enable;
    logic timeout_flag_q;

    assign cnt_clear  = (state == LAUNCH);
    assign cnt_enable = (state == DRAW) && !line_done;

    asc_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (tmo_expired)
    );

    // A completion arriving on the limit cycle wins over the abort.
    assign timeout_hit  = (state == DRAW) && tmo_expired && !line_done;
    assign line_abort   = timeout_hit;
    assign timeout_flag = timeout_flag_q;
`else
    assign timeout_hit  = 1'b0;
    assign line_abort   = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
`ifdef ASC_CTRL_TIMEOUT_EN
            timeout_flag_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    start_q <= 1'b0;
                    if (go_accept) begin
                        state   <= LAUNCH;
                        start_q <= 1'b1;
`ifdef ASC_CTRL_TIMEOUT_EN
                        timeout_flag_q <= 1'b0;
`endif
                    end
                end
                LAUNCH: begin
                    state   <= DRAW;
                    start_q <= 1'b0;
                end
                DRAW: begin
                    start_q <= 1'b0;
                    if (draw_end) begin
                        state <= IDLE;
                    end
`ifdef ASC_CTRL_TIMEOUT_EN
                    if (timeout_hit) begin
                        timeout_flag_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
